// File: rtl/territory_scanner.sv
// Full-framebuffer ownership scan: counts the pixels held by each of four players.
// Define TERRITORY_SCAN_SKIP_TIMER_ROW_EN to leave row 119 (the timer bar) out of the scan.
module territory_scanner (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    output logic [14:0] rd_address,
    input  logic [2:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic [14:0] p1_count,
    output logic [14:0] p2_count,
    output logic [14:0] p3_count,
    output logic [14:0] p4_count,
    output logic [1:0]  winner,
    output logic        tie
);

    localparam logic [7:0] XMAX = 8'd159;
`ifdef TERRITORY_SCAN_SKIP_TIMER_ROW_EN
    localparam logic [6:0] YMAX = 7'd118;
`else
    localparam logic [6:0] YMAX = 7'd119;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    state_t            state;
    logic              rd_pending;
    logic [3:0][14:0]  cnt_q;
    logic [3:0][14:0]  cnt_d;
    logic [14:0]       best;
    logic [1:0]        win_d;
    logic [2:0]        n_max;
    logic              tie_d;
    logic [7:0]        x;
    logic [6:0]        y;

    assign x        = rd_address[14:7];
    assign y        = rd_address[6:0];
    assign p1_count = cnt_q[0];
    assign p2_count = cnt_q[1];
    assign p3_count = cnt_q[2];
    assign p4_count = cnt_q[3];

    // rd_pending marks the cycle in which rd_data belongs to the previous address
    always_comb begin
        cnt_d = cnt_q;
        if (rd_pending) begin
            unique case (rd_data)
                3'b001:  cnt_d[0] = cnt_q[0] + 15'd1;
                3'b010:  cnt_d[1] = cnt_q[1] + 15'd1;
                3'b100:  cnt_d[2] = cnt_q[2] + 15'd1;
                3'b110:  cnt_d[3] = cnt_q[3] + 15'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Judged on the post-flush counts so DONE sees the final read
    always_comb begin
        best  = cnt_d[0];
        win_d = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cnt_d[i] > best) begin
                best  = cnt_d[i];
                win_d = 2'(i);
            end
        end
        n_max = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (cnt_d[i] == best) n_max = n_max + 3'd1;
        end
        tie_d = (n_max > 3'd1);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rd_address <= 15'd0;
            rd_pending <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_q      <= '0;
            winner     <= 2'd0;
            tie        <= 1'b0;
        end else begin
            done       <= 1'b0;
            cnt_q      <= cnt_d;
            rd_pending <= (state == SCAN);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SCAN;
                        rd_address <= 15'd0;
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (y == YMAX) begin
                        if (x == XMAX) begin
                            state <= FLUSH;
                        end else begin
                            rd_address <= {x + 8'd1, 7'd0};
                        end
                    end else begin
                        rd_address <= {x, y + 7'd1};
                    end
                end
                FLUSH: begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    winner <= win_d;
                    tie    <= tie_d;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_territory_scanner.sv
// Bench for territory_scanner: synchronous framebuffer model plus ownership reference.
// Honours TERRITORY_SCAN_SKIP_TIMER_ROW_EN the same way as the design.
module tb_territory_scanner;

`ifdef TERRITORY_SCAN_SKIP_TIMER_ROW_EN
    localparam int YMAX = 118;
`else
    localparam int YMAX = 119;
`endif
    localparam int ROWS  = YMAX + 1;
    localparam int NSCAN = 160 * ROWS;

    logic        CLOCK_50;
    logic        resetn;
    logic        start;
    logic [14:0] rd_address;
    logic [2:0]  rd_data;
    logic        busy;
    logic        done;
    logic [14:0] p1_count;
    logic [14:0] p2_count;
    logic [14:0] p3_count;
    logic [14:0] p4_count;
    logic [1:0]  winner;
    logic        tie;

    logic [2:0]  fb [0:32767];

    int checks   = 0;
    int failures = 0;
    int exp_cnt [4];
    int exp_win;
    int exp_tie;

    territory_scanner dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .rd_address (rd_address),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .p1_count   (p1_count),
        .p2_count   (p2_count),
        .p3_count   (p3_count),
        .p4_count   (p4_count),
        .winner     (winner),
        .tie        (tie)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rd_data <= fb[rd_address];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        int best;
        int nbest;
        for (int p = 0; p < 4; p++) exp_cnt[p] = 0;
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < ROWS; y++) begin
                case (fb[x * 128 + y])
                    3'b001:  exp_cnt[0]++;
                    3'b010:  exp_cnt[1]++;
                    3'b100:  exp_cnt[2]++;
                    3'b110:  exp_cnt[3]++;
                    default: ;
                endcase
            end
        end
        best = -1;
        exp_win = 0;
        for (int p = 0; p < 4; p++) begin
            if (exp_cnt[p] > best) begin
                best    = exp_cnt[p];
                exp_win = p;
            end
        end
        nbest = 0;
        for (int p = 0; p < 4; p++) if (exp_cnt[p] == best) nbest++;
        exp_tie = (nbest > 1) ? 1 : 0;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_p1"}, 32'(p1_count), exp_cnt[0]);
        check({tag, "_p2"}, 32'(p2_count), exp_cnt[1]);
        check({tag, "_p3"}, 32'(p3_count), exp_cnt[2]);
        check({tag, "_p4"}, 32'(p4_count), exp_cnt[3]);
        check({tag, "_winner"}, 32'(winner), exp_win);
        check({tag, "_tie"}, 32'(tie), exp_tie);
    endtask

    task automatic fill(input logic [2:0] v);
        for (int a = 0; a < 32768; a++) fb[a] = v;
    endtask

    task automatic place(input int n, input logic [2:0] v,
                         input logic [2:0] bg);
        int placed;
        int a;
        placed = 0;
        while (placed < n) begin
            a = $urandom_range(0, 159) * 128 + $urandom_range(0, YMAX);
            if (fb[a] == bg) begin
                fb[a] = v;
                placed++;
            end
        end
    endtask

    // t counts cycles after the start edge: t=1 is the first SCAN cycle
    task automatic run_scan(input string tag, input int restart_at);
        int t;
        int t_done;
        int addr_err;
        int busy_err;
        int i;
        logic [14:0] ea;
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start    = 1'b0;
        t        = 1;
        t_done   = -1;
        addr_err = 0;
        busy_err = 0;
        while (t <= NSCAN + 10) begin
            if (done === 1'b1) begin
                t_done = t;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            i  = (t <= NSCAN) ? t - 1 : NSCAN - 1;
            ea = 15'((i / ROWS) * 128 + (i % ROWS));
            if (rd_address !== ea) addr_err++;
            start = (restart_at > 0 && t == restart_at) ? 1'b1 : 1'b0;
            @(posedge CLOCK_50); #1;
            t++;
        end
        start = 1'b0;
        check({tag, "_done_time"}, t_done, NSCAN + 2);
        check({tag, "_busy_errs"}, busy_err, 0);
        check({tag, "_addr_errs"}, addr_err, 0);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        model();
        check_results(tag);
        @(posedge CLOCK_50); #1;
        check({tag, "_done_pulse"}, 32'(done), 0);
        repeat (20) @(posedge CLOCK_50);
        #1;
        check_results({tag, "_hold"});
    endtask

    initial begin
        int v;
        int done_seen;
        resetn = 1'b0;
        start  = 1'b0;
        fill(3'b000);
        #25;
        check("rst_addr", 32'(rd_address), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_p1", 32'(p1_count), 0);
        check("rst_winner", 32'(winner), 0);
        check("rst_tie", 32'(tie), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        run_scan("zero", 0);
        check("zero_tie_set", 32'(tie), 1);

        fill(3'b111);
        place(100, 3'b010, 3'b111);
        place(40, 3'b110, 3'b111);
        run_scan("p2p4", 0);
        check("p2p4_p2_exact", 32'(p2_count), 100);
        check("p2p4_winner_p2", 32'(winner), 1);

        fill(3'b000);
        place(500, 3'b001, 3'b000);
        place(500, 3'b100, 3'b000);
        run_scan("p1p3_tie", 3000);
        check("p1p3_winner_low", 32'(winner), 0);
        check("p1p3_tie_set", 32'(tie), 1);

        for (int a = 0; a < 32768; a++) fb[a] = 3'($urandom_range(0, 7));
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (4999) @(posedge CLOCK_50);
        #5;
        resetn = 1'b0;
        #1;
        check("midrst_addr", 32'(rd_address), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_p1", 32'(p1_count), 0);
        check("midrst_p2", 32'(p2_count), 0);
        check("midrst_p3", 32'(p3_count), 0);
        check("midrst_p4", 32'(p4_count), 0);
        check("midrst_winner", 32'(winner), 0);
        check("midrst_tie", 32'(tie), 0);
        @(negedge CLOCK_50);
        resetn    = 1'b1;
        done_seen = 0;
        repeat (50) begin
            @(posedge CLOCK_50); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midrst_idle_after", done_seen, 0);

        for (int a = 0; a < 32768; a++) begin
            v = $urandom_range(0, 6);
            if (v >= 4) v++;
            fb[a] = 3'(v);
        end
        for (int x = 0; x < 160; x++) fb[x * 128 + 119] = 3'b100;
        run_scan("row119", 0);
        check("row119_p3", 32'(p3_count), (YMAX == 119) ? 160 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
